io_peripheral_unit: RTL and testbench
=====================================

IO_PERIPHERAL_UNIT -- requirements
Module: io_peripheral_unit

Interface
REQ-001 Parameter XLEN, 32, data and address width.
REQ-002 Parameter DEBOUNCE_CYCLES, 50000, cycles a key input must stay stable before it is accepted (1 ms at 50 MHz).
REQ-003 clock  input  1  single clock; every flop in the block SHALL use its rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 address  input  XLEN  byte address from the MEM-stage ALU result.
REQ-006 write_data  input  XLEN  store data.
REQ-007 write_enable  input  1  store strobe, one cycle per store.
REQ-008 read_enable  input  1  load strobe.
REQ-009 read_data  output  XLEN  load data; combinational from registered state.
REQ-010 io_select  output  1  high when address[31:12] == 0x40000.
REQ-011 SW  input  10  raw board switches (asynchronous).
REQ-012 KEY  input  3  raw board KEY[3:1], active-low, asynchronous.
REQ-013 LED  output  10  LEDR register.
REQ-014 HEX0..HEX5  output  7 each  active-low segment drives.

Function
REQ-015 Address map, offsets from 0x40000000:
- 0x000 LEDR, rw, bits [9:0]
- 0x100 SW, ro
- 0x200 KEY_STATE, ro, debounced, active-high
- 0x204 KEY_EDGE, read / write-1-to-clear
- 0x300, 0x304, 0x308, 0x30C, 0x310, 0x314: HEX0..HEX5 raw segment registers, rw, bits [6:0]
- 0x318 HEX_VALUE, rw, bits [23:0]
- 0x31C HEX_MODE, rw, bit 0
REQ-016 A register SHALL update on the clock edge where io_select && write_enable && its offset matches; only the listed bits are stored.
REQ-017 Writes to ro offsets and to unmapped offsets SHALL be ignored.
REQ-018 Reads SHALL return register bits zero-extended to XLEN. Reads of unmapped offsets, or with io_select low, SHALL return 0.
REQ-019 read_data SHALL NOT depend on read_enable. Reads have no side effects.
REQ-020 SW SHALL pass through a 2-flop synchronizer; a read returns the synchronized value (2-cycle latency).
REQ-021 Each KEY bit SHALL be inverted, 2-flop synchronized, then debounced:
- while the synced value equals the stable value, the counter is 0
- otherwise the counter increments
- on the cycle the counter reaches DEBOUNCE_CYCLES-1, the stable value takes the synced value and the counter clears
- any return to equality before then clears the counter
REQ-022 A 0->1 transition of a stable key bit SHALL set the matching KEY_EDGE bit.
REQ-023 A write to KEY_EDGE clears each bit written as 1. If set and clear coincide on the same bit, set wins.
REQ-024 HEX_MODE=0: HEXn = ~raw register n.
REQ-025 HEX_MODE=1: HEXn = 7-segment decode of HEX_VALUE[4n+3:4n], active-low, hex digits 0-F.
REQ-026 The mode switch SHALL take effect on the output in the cycle after the HEX_MODE write edge.

Reset
REQ-027 When reset is high at a clock edge:
- LED, raw HEX registers, HEX_VALUE, HEX_MODE and KEY_EDGE SHALL become 0
- synchronizers, stable key values and debounce counters SHALL become 0
REQ-028 After reset, HEX0..HEX5 SHALL be 7'h7F (all segments dark) and read_data for every mapped offset SHALL be 0.
REQ-029 Reset mid-debounce SHALL discard the pending count. Reset SHALL override a simultaneous write.

Structure
REQ-030 The base address, all offsets, DEBOUNCE_CYCLES default and the 7-segment code table SHALL live in the shared RISC-V header/package.
REQ-031 Debouncing SHALL be one sub-module, key_debouncer (synchronizer, counter and stable flop for one bit), instantiated three times.
REQ-032 The 7-segment decode SHALL reuse the existing dec7seg block.

Verification (DEBOUNCE_CYCLES=4 in bench)
REQ-033 Write 0x3FF to 0x40000000, then read it back -> LED=0x3FF, read_data=0x000003FF; a later write of 0xFFFFFC00 -> LED=0.
REQ-034 Hold KEY=3'b110 for 10 cycles -> KEY_STATE=0x1 and KEY_EDGE=0x1. Write 0x1 to 0x40000204 -> KEY_EDGE=0.
REQ-035 Glitch KEY[1] low for 2 cycles -> KEY_STATE remains 0 and KEY_EDGE remains 0.
REQ-036 Key edge in the same cycle as a W1C write to that bit -> KEY_EDGE bit stays 1.
REQ-037 Write 0x123456 to 0x318 and 1 to 0x31C -> HEX0 = decode(6) ... HEX5 = decode(1). Write 0 to 0x31C with raw HEX0=0x3F -> HEX0=0x40.
REQ-038 Apply reset during debounce with LED=0x155 -> LED=0, HEX all 0x7F, KEY_STATE=0. A read of 0x40000400 -> 0.

Source files
------------

// File: rtl/io_peripheral_unit_pkg.sv
// Shared memory-mapped I/O constants: base address, register offsets,
// debounce default and the active-low 7-segment code table.
package io_peripheral_unit_pkg;

  localparam logic [31:0] IO_BASE = 32'h4000_0000;
  localparam logic [19:0] IO_PAGE = 20'h40000;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  localparam logic [11:0] OFF_LEDR      = 12'h000;
  localparam logic [11:0] OFF_SW        = 12'h100;
  localparam logic [11:0] OFF_KEY_STATE = 12'h200;
  localparam logic [11:0] OFF_KEY_EDGE  = 12'h204;
  localparam logic [11:0] OFF_HEX0      = 12'h300;
  localparam logic [11:0] OFF_HEX1      = 12'h304;
  localparam logic [11:0] OFF_HEX2      = 12'h308;
  localparam logic [11:0] OFF_HEX3      = 12'h30C;
  localparam logic [11:0] OFF_HEX4      = 12'h310;
  localparam logic [11:0] OFF_HEX5      = 12'h314;
  localparam logic [11:0] OFF_HEX_VALUE = 12'h318;
  localparam logic [11:0] OFF_HEX_MODE  = 12'h31C;

  // Active-low segment codes {g,f,e,d,c,b,a} for hex digits 0-F.
  localparam logic [6:0] SEG7_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/io_peripheral_unit_if.sv
// CPU-side load/store bus into the I/O block.
interface io_peripheral_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] write_data;
  logic            write_enable;
  logic            read_enable;
  logic [XLEN-1:0] read_data;
  logic            io_select;

  modport master (
    output address, write_data, write_enable, read_enable,
    input  read_data, io_select
  );

  modport slave (
    input  address, write_data, write_enable, read_enable,
    output read_data, io_select
  );
endinterface

// File: rtl/io_peripheral_unit_dec7seg.sv
// Hex digit to active-low 7-segment pattern.
module dec7seg
  import io_peripheral_unit_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  assign seg = SEG7_CODE[digit];
endmodule

// File: rtl/io_peripheral_unit_key_debouncer.sv
// One key bit: invert (keys are active-low), 2-flop synchronize, then accept
// the synchronized level only after it has differed from the stable level for
// DEBOUNCE_CYCLES consecutive cycles. rise pulses on the accepting edge of a
// 0->1 change so the edge register sets together with the stable value.
module key_debouncer
  import io_peripheral_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic stable,
  output logic rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  assign rise = sync_p1 && !stable && (cnt == LAST);

  // Synchronizer chain plus the debounce counter and accepted level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= ~key_n;
      sync_p1 <= sync_p0;
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/io_peripheral_unit.sv
// Memory-mapped board I/O: LEDs, switches, debounced keys with edge capture,
// and six 7-segment displays driven either raw or as a hex number.
module io_peripheral_unit
  import io_peripheral_unit_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  io_peripheral_unit_if.slave  bus,
  input  logic [9:0]           SW,
  input  logic [2:0]           KEY,
  output logic [9:0]           LED,
  output logic [6:0]           HEX0,
  output logic [6:0]           HEX1,
  output logic [6:0]           HEX2,
  output logic [6:0]           HEX3,
  output logic [6:0]           HEX4,
  output logic [6:0]           HEX5
);
  logic            io_select;
  logic [11:0]     offset;
  logic            wr;
  logic [2:0]      hex_idx;
  logic [9:0]      led_reg;
  logic [6:0]      hex_raw [6];
  logic [23:0]     hex_value;
  logic            hex_mode;
  logic [2:0]      key_edge;
  logic [2:0]      key_state;
  logic [2:0]      key_rise;
  logic [2:0]      edge_clr;
  logic [9:0]      sw_p0;
  logic [9:0]      sw_p1;
  logic [6:0]      dec_seg [6];
  logic [6:0]      hex_out [6];
  logic [XLEN-1:0] rd;
  logic            unused_bits;

  assign io_select     = (bus.address[XLEN-1:12] == (XLEN-12)'(IO_PAGE));
  assign bus.io_select = io_select;
  assign offset        = bus.address[11:0];
  assign wr            = io_select && bus.write_enable;
  // HEX0..HEX5 sit at 0x300 + 4n, so bits [4:2] are the display index.
  assign hex_idx       = offset[4:2];
  assign edge_clr      = (wr && offset == OFF_KEY_EDGE) ? bus.write_data[2:0] : 3'b000;
  assign unused_bits   = ^{bus.read_enable, bus.write_data[XLEN-1:24]};

  // Writable LED / display registers; reset wins over a coincident store.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_reg   <= '0;
      hex_value <= '0;
      hex_mode  <= 1'b0;
      for (int i = 0; i < 6; i++) hex_raw[i] <= '0;
    end else if (wr) begin
      case (offset)
        OFF_LEDR:      led_reg <= bus.write_data[9:0];
        OFF_HEX0, OFF_HEX1, OFF_HEX2,
        OFF_HEX3, OFF_HEX4, OFF_HEX5:
                       hex_raw[hex_idx] <= bus.write_data[6:0];
        OFF_HEX_VALUE: hex_value <= bus.write_data[23:0];
        OFF_HEX_MODE:  hex_mode <= bus.write_data[0];
        default: ;
      endcase
    end
  end

  // Switch synchronizer and key edge capture; a new edge beats a W1C clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_p0    <= '0;
      sw_p1    <= '0;
      key_edge <= '0;
    end else begin
      sw_p0    <= SW;
      sw_p1    <= sw_p0;
      key_edge <= (key_edge & ~edge_clr) | key_rise;
    end
  end

  // Load data mux; purely a function of address and registered state.
  always_comb begin
    rd = '0;
    if (io_select) begin
      case (offset)
        OFF_LEDR:      rd[9:0]  = led_reg;
        OFF_SW:        rd[9:0]  = sw_p1;
        OFF_KEY_STATE: rd[2:0]  = key_state;
        OFF_KEY_EDGE:  rd[2:0]  = key_edge;
        OFF_HEX0, OFF_HEX1, OFF_HEX2,
        OFF_HEX3, OFF_HEX4, OFF_HEX5:
                       rd[6:0]  = hex_raw[hex_idx];
        OFF_HEX_VALUE: rd[23:0] = hex_value;
        OFF_HEX_MODE:  rd[0]    = hex_mode;
        default: ;
      endcase
    end
  end
  assign bus.read_data = rd;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock  (clock),
      .reset  (reset),
      .key_n  (KEY[k]),
      .stable (key_state[k]),
      .rise   (key_rise[k])
    );
  end

  for (genvar n = 0; n < 6; n++) begin : g_hex
    dec7seg u_dec (
      .digit (hex_value[4*n +: 4]),
      .seg   (dec_seg[n])
    );
    assign hex_out[n] = hex_mode ? dec_seg[n] : ~hex_raw[n];
  end

  assign LED  = led_reg;
  assign HEX0 = hex_out[0];
  assign HEX1 = hex_out[1];
  assign HEX2 = hex_out[2];
  assign HEX3 = hex_out[3];
  assign HEX4 = hex_out[4];
  assign HEX5 = hex_out[5];
endmodule

// File: tb/tb_io_peripheral_unit.sv
// Bench for io_peripheral_unit: directed scenarios followed by random bus and
// board activity. A behavioural model predicts every cycle's outputs, the
// prediction is queued, and a negedge monitor compares the DUT against it.
module tb_io_peripheral_unit;
  localparam int DC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sw    = '0;
  logic [2:0] key   = 3'b111;
  logic [9:0] led;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  io_peripheral_unit_if #(.XLEN(32)) bus ();

  io_peripheral_unit #(.XLEN(32), .DEBOUNCE_CYCLES(DC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .SW    (sw),
    .KEY   (key),
    .LED   (led),
    .HEX0  (hex0),
    .HEX1  (hex1),
    .HEX2  (hex2),
    .HEX3  (hex3),
    .HEX4  (hex4),
    .HEX5  (hex5)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        sel;
    logic [31:0] rd;
    logic [9:0]  led;
    logic [41:0] hex;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Behavioural model of the register file and board inputs.
  logic [9:0]  m_led = '0;
  logic [6:0]  m_raw [6] = '{default: '0};
  logic [23:0] m_val = '0;
  logic        m_mode = 1'b0;
  logic [2:0]  m_edge = '0;
  logic [2:0]  m_stable = '0;
  int          m_run [3] = '{0, 0, 0};
  logic [9:0]  sw_h1 = '0, sw_h2 = '0;
  logic [2:0]  k_h1 = '0, k_h2 = '0;

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [41:0] model_hex();
    logic [41:0] h;
    for (int i = 0; i < 6; i++)
      h[7*i +: 7] = m_mode ? seg_ref(m_val[4*i +: 4]) : ~m_raw[i];
    return h;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int o;
    if (a[31:12] != 20'h40000) return 32'h0;
    o = int'(a[11:0]);
    case (o)
      'h000: return {22'h0, m_led};
      'h100: return {22'h0, sw_h2};
      'h200: return {29'h0, m_stable};
      'h204: return {29'h0, m_edge};
      'h300, 'h304, 'h308, 'h30C, 'h310, 'h314: return {25'h0, m_raw[(o - 'h300) / 4]};
      'h318: return {8'h0, m_val};
      'h31C: return {31'h0, m_mode};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
    logic [2:0] rise;
    logic [2:0] clr;
    int         o;
    if (r) begin
      m_led = '0; m_val = '0; m_mode = 1'b0; m_edge = '0; m_stable = '0;
      for (int i = 0; i < 6; i++) m_raw[i] = '0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      sw_h1 = '0; sw_h2 = '0; k_h1 = '0; k_h2 = '0;
      return;
    end
    rise = '0;
    for (int b = 0; b < 3; b++) begin
      if (k_h2[b] != m_stable[b]) begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          rise[b]     = k_h2[b];
          m_stable[b] = k_h2[b];
          m_run[b]    = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    o   = int'(a[11:0]);
    clr = (we && a[31:12] == 20'h40000 && o == 'h204) ? d[2:0] : 3'b000;
    m_edge = (m_edge & ~clr) | rise;
    k_h2 = k_h1; k_h1 = ~key;
    sw_h2 = sw_h1; sw_h1 = sw;
    if (we && a[31:12] == 20'h40000) begin
      case (o)
        'h000: m_led = d[9:0];
        'h300, 'h304, 'h308, 'h30C, 'h310, 'h314: m_raw[(o - 'h300) / 4] = d[6:0];
        'h318: m_val = d[23:0];
        'h31C: m_mode = d[0];
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive inputs, queue the prediction, advance the model at the edge.
  task automatic cycle(input logic r, input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    reset            = r;
    bus.address      = a;
    bus.write_data   = d;
    bus.write_enable = we;
    bus.read_enable  = re;
    e.sel = (a[31:12] == 20'h40000);
    e.rd  = model_read(a);
    e.led = m_led;
    e.hex = model_hex();
    sb.push_back(e);
    @(posedge clock);
    model_edge(r, we, a, d);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1'b0, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the queue head.
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("io_select", 64'(bus.io_select), 64'(e.sel));
      check("read_data", 64'(bus.read_data), 64'(e.rd));
      check("LED", 64'(led), 64'(e.led));
      check("HEX", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(e.hex));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [11:0] OFFS [14] = '{12'h000, 12'h100, 12'h200, 12'h204, 12'h300,
    12'h304, 12'h308, 12'h30C, 12'h310, 12'h314, 12'h318, 12'h31C, 12'h400, 12'h302};

  initial begin
    logic [31:0] a;
    logic [31:0] base;
    int          op;
    bus.address = '0; bus.write_data = '0; bus.write_enable = 1'b0; bus.read_enable = 1'b0;
    @(posedge clock); #1;

    // Reset state: every mapped offset reads 0, displays dark.
    cycle(1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'h0);
    for (int i = 0; i < 14; i++) rd(32'h4000_0000 | 32'(OFFS[i]));

    // LED write / read-back, then only the listed bits are stored.
    wr(32'h4000_0000, 32'h0000_03FF);
    rd(32'h4000_0000);
    wr(32'h4000_0000, 32'hFFFF_FC00);
    rd(32'h4000_0000);

    // Writes to read-only, unmapped and non-I/O addresses are ignored.
    wr(32'h4000_0100, 32'hFFFF_FFFF);
    wr(32'h4000_0400, 32'hFFFF_FFFF);
    wr(32'h0000_0000, 32'hFFFF_FFFF);
    rd(32'h0000_0000);
    rd(32'h4000_0000);

    // Hold KEY[0] pressed: debounced state and edge set; then W1C.
    key = 3'b110;
    for (int i = 0; i < 10; i++) rd(32'h4000_0200);
    rd(32'h4000_0204);
    wr(32'h4000_0204, 32'h1);
    rd(32'h4000_0204);
    key = 3'b111;
    for (int i = 0; i < 10; i++) rd(32'h4000_0200);

    // Short glitch on KEY[1] is rejected.
    key = 3'b101;
    rd(32'h4000_0200); rd(32'h4000_0204);
    key = 3'b111;
    for (int i = 0; i < 8; i++) rd((i % 2) ? 32'h4000_0204 : 32'h4000_0200);

    // Edge on KEY[1] coinciding with a W1C of that bit: set wins.
    key = 3'b101;
    for (int i = 0; i < 20 && !m_stable[1]; i++) wr(32'h4000_0204, 32'h2);
    rd(32'h4000_0204);
    key = 3'b111;
    for (int i = 0; i < 10; i++) rd(32'h4000_0200);

    // Hex mode decode, then back to raw mode.
    wr(32'h4000_0318, 32'h0012_3456);
    wr(32'h4000_031C, 32'h1);
    rd(32'h4000_0318);
    wr(32'h4000_0300, 32'h3F);
    wr(32'h4000_031C, 32'h0);
    rd(32'h4000_0300);
    rd(32'h4000_031C);

    // Reset during a debounce with LEDs lit.
    wr(32'h4000_0000, 32'h155);
    key = 3'b011;
    for (int i = 0; i < 4; i++) rd(32'h4000_0200);
    cycle(1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'h3FF);
    key = 3'b111;
    rd(32'h4000_0200);
    rd(32'h4000_0400);
    rd(32'h4000_0000);
    for (int i = 0; i < 6; i++) rd(32'h4000_0200);

    // Random traffic with switch and key activity.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) sw = 10'($urandom);
      if ($urandom_range(0, 7) == 0) key = 3'($urandom);
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 9))
        0:       base = 32'h4000_1000;
        1:       base = 32'h0000_0000;
        default: base = 32'h4000_0000;
      endcase
      a = base | 32'(OFFS[$urandom_range(0, 13)]);
      if ($urandom_range(0, 99) == 0)
        cycle(1'b1, 1'b0, 1'b0, a, $urandom);
      else if (op < 4)
        wr(a, $urandom);
      else if (op < 8)
        rd(a);
      else
        cycle(1'b0, 1'b0, 1'b0, a, $urandom);
    end

    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    @(negedge clock); #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
